// File: rtl/sa_fp_pkg.sv
// Shared fp32 multiplier types: operand type, result-routing tag and multiplier latency.
package sa_fp_pkg;

  localparam int unsigned FMUL_LAT = 2;
  localparam int unsigned TAG_ID_W = 4;

  typedef logic [31:0] fp32_t;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } mul_tag_t;

endpackage

// File: rtl/rr_grant.sv
// N-way round-robin priority encoder: first set request searching from ptr+1 modulo N.
module rr_grant #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  logic [IW-1:0] cand;

  // Walk from the farthest slot back to the nearest so the nearest requester wins.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    cand  = '0;
    for (int k = N; k > 0; k--) begin
      cand = IW'((32'(ptr) + 32'(k)) % N);
      if (req[cand]) begin
        gnt_c       = '0;
        gnt_c[cand] = 1'b1;
        idx_c       = cand;
        any_c       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmul_rr_arbiter.sv
// Round-robin sharing of one fp32 multiplier among N_REQ requesters; a tag pipeline
// shadowing the multiplier steers each product back to its issuer.
module fmul_rr_arbiter
  import sa_fp_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MUL_LAT = FMUL_LAT,
  localparam int unsigned ID_W   = $clog2(N_REQ)
) (
  input  logic                aclk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*32-1:0] req_a,
  input  logic [N_REQ*32-1:0] req_b,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [31:0]         rsp_data,
  output logic                mul_tvalid,
  output logic [31:0]         mul_a_tdata,
  output logic [31:0]         mul_b_tdata,
  input  logic                mul_res_tvalid,
  input  logic [31:0]         mul_res_tdata,
  output logic [ID_W+1:0]     inflight,
  output logic                err_orphan
);

  localparam int unsigned CNT_W = ID_W + 2;
  localparam int unsigned SET_W = $clog2(MUL_LAT + 2);

  logic [N_REQ-1:0] gnt_c;
  logic [ID_W-1:0]  win_c;
  logic             any_c;
  logic             accept_c;
  fp32_t            sel_a_c, sel_b_c;
  mul_tag_t         tag_out_c;

  logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
  mul_tag_t [MUL_LAT-1:0]    tag_q, tag_d;
  fp32_t                     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [N_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  fp32_t                     rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]          inflight_q, inflight_d;
  logic                      err_q, err_d;
  logic [SET_W-1:0]          settle_q, settle_d;

  rr_grant #(.N(N_REQ)) u_grant (
    .ptr   (rr_ptr_q),
    .req   (req_valid),
    .gnt_c (gnt_c),
    .idx_c (win_c),
    .any_c (any_c)
  );

  assign req_ready   = rst ? '0 : gnt_c;
  assign accept_c    = any_c & ~rst;
  assign tag_out_c   = tag_q[MUL_LAT-1];
  assign mul_tvalid  = accept_c;
  assign mul_a_tdata = accept_c ? sel_a_c : mul_a_q;
  assign mul_b_tdata = accept_c ? sel_b_c : mul_b_q;

  // Winner operand mux.
  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_c == ID_W'(i)) begin
        sel_a_c = req_a[32*i +: 32];
        sel_b_c = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    rr_ptr_d    = accept_c ? win_c : rr_ptr_q;
    mul_a_d     = mul_a_tdata;
    mul_b_d     = mul_b_tdata;

    tag_d        = tag_q;
    tag_d[0].vld = accept_c;
    tag_d[0].id  = TAG_ID_W'(win_c);
    for (int s = 1; s < MUL_LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end

    // Results are only delivered when the tag and the multiplier agree.
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_out_c.vld && mul_res_tvalid) begin
      rsp_data_d = mul_res_tdata;
      for (int i = 0; i < N_REQ; i++) begin
        if (tag_out_c.id == TAG_ID_W'(i)) rsp_valid_d[i] = 1'b1;
      end
    end

    // Stale multiplier output after reset is ignored until the settle count expires.
    err_d    = err_q | ((tag_out_c.vld != mul_res_tvalid) && (settle_q == '0));
    settle_d = (settle_q != '0) ? settle_q - SET_W'(1) : settle_q;

    case ({accept_c, tag_out_c.vld})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      tag_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
      settle_q    <= SET_W'(MUL_LAT + 1);
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag_q       <= tag_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
      settle_q    <= settle_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign inflight   = inflight_q;
  assign err_orphan = err_q;

endmodule
